uart_tx_framer: RTL and testbench
=================================

// Module: uart_tx_framer
// PURPOSE
//  Configurable UART transmit framer; parametrised successor of the fixed 10-bit frame sequencer.
//  Accepts one data word per valid/ready handshake and serialises it on tx, one bit per baud_tick.
//  Frame format is selectable at runtime: 5..MAX_DATA_BITS data bits, optional even/odd parity, 1 or 2 stop bits.
//  Sits between the TX FIFO/host interface and the pad; baud_tick comes from the shared baud generator.
// PARAMETERS
//  MAX_DATA_BITS  9  widest supported data field (legal range 5..9)
//  IDX_W          4  width of bit_idx; must hold MAX_DATA_BITS+3
// PORTS
//  clk            in   1              single clock
//  rst            in   1              synchronous, active-high reset
//  baud_tick      in   1              1-cycle pulse per baud interval
//  tx_valid       in   1              data word offered
//  tx_data        in   MAX_DATA_BITS  word, LSB sent first
//  tx_ready       out  1              framer idle; combinational, = (state==IDLE)
//  cfg_data_bits  in   4              data field length; <5 -> 5, >MAX_DATA_BITS -> MAX_DATA_BITS
//  cfg_parity_en  in   1              1 = insert parity bit after data
//  cfg_parity_odd in   1              1 = odd parity, 0 = even
//  cfg_two_stop   in   1              1 = two stop bits
//  tx             out  1              serial line, idle high
//  bit_idx        out  IDX_W          current frame position, 0 = start bit
//  busy           out  1              high while a frame is on the line
//  done           out  1              1-cycle pulse at frame completion
// BEHAVIOUR
//  Reset (clk edge with rst=1): state=IDLE, tx=1, bit_idx=0, busy=0, done=0, shift reg and latched cfg cleared.
//  Accept: tx_valid && tx_ready on an edge. tx_data and all cfg_* are latched at that edge; later changes
//   are ignored until the next accept. Bits of tx_data above the latched length are ignored.
//  From the cycle after accept: state=START, tx=0, busy=1, bit_idx=0. A baud_tick in the accept cycle is ignored.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. Each state/bit advances only on a baud_tick.
//   START: on tick -> DATA, tx=data[0].
//   DATA: on tick shift right; after data_bits ticks -> PARITY if enabled, else STOP.
//   PARITY: tx = ^(masked data) ^ parity_odd; on tick -> STOP.
//   STOP: tx=1; on the 1st tick (or 2nd if two_stop) -> IDLE.
//  bit_idx increments by 1 on every tick while busy; last value = data_bits + parity_en + stop_bits.
//  On the final STOP tick edge: busy=0, bit_idx=0, done=1 for exactly one cycle; tx stays 1.
//  tx_ready is high in the same cycle as done, so a back-to-back accept is legal then: zero idle cycles, and
//   the next start bit is driven from the following cycle.
//  tx_valid while busy: tx_ready=0, no effect. tx_valid may drop without acceptance (no protocol error).
//  rst mid-frame: the frame is abandoned; tx=1 from the next cycle and done is not pulsed.
//  tx is registered (glitch-free); no combinational path from tx_data or cfg_* to tx.
// STRUCTURE
//  uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), MAX_DATA_BITS default, IDX_W, and a
//   clamp_data_bits() function, all shared with the future RX framer.
//  Sub-module uart_parity_gen: combinational masked-XOR parity of the data and length, shared with RX.
//  Top level: the FSM, shift register, bit counter and stop counter.
// TESTING
//  8N1, tx_data=0x55, tick every 16 clk -> tx = 0,1,0,1,0,1,0,1,0,1; bit_idx 0..9; one done pulse; busy for 10 ticks.
//  7E1, tx_data=0xA3 -> tx = 0,1,1,0,0,0,1,0,1(par),1(stop); done after the 10th tick.
//  8O2, tx_data=0x0F -> tx = 0,1,1,1,1,0,0,0,0,1(par),1,1; bit_idx reaches 11; done after the 12th tick.
//  tx_valid held high over two frames -> second start bit begins the cycle after done; valid during busy ignored.
//  Accept coinciding with baud_tick -> the tick is ignored; start bit lasts until the next tick.
//  rst asserted at bit_idx=4 -> next cycle tx=1, busy=0, bit_idx=0, done stays 0; a following 0x55 8N1 frame is correct.
//  Config changed mid-frame -> current frame unaffected; the new config applies only after the next accept.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default geometry and
// data-length clamping used by both the TX and RX framers.
package uart_pkg;

  localparam int UART_MAX_DATA_BITS = 9;
  localparam int UART_IDX_W         = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Out-of-range lengths snap to the nearest legal value rather than erroring.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] cfg, input int max_bits);
    logic [3:0] res;
    if (cfg < 4'd5) begin
      res = 4'd5;
    end else if (int'(cfg) > max_bits) begin
      res = 4'(max_bits);
    end else begin
      res = cfg;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Parity over the low 'len' bits of a data word; bits above the length are masked off.
module uart_parity_gen #(
  parameter int W = 9
) (
  input  logic [W-1:0] data,
  input  logic [3:0]   len,
  input  logic         odd,
  output logic         parity
);

  logic [W-1:0] mask_s;

  function automatic logic masked_parity(input logic [W-1:0] d, input logic [W-1:0] m);
    return ^(d & m);
  endfunction

  for (genvar g = 0; g < W; g++) begin : g_mask
    assign mask_s[g] = (len > 4'(g));
  end

  assign parity = masked_parity(data, mask_s) ^ odd;

endmodule

// File: rtl/uart_tx_framer.sv
// Runtime-configurable UART transmit framer: one word per valid/ready handshake,
// serialised LSB first on a registered tx line, one bit per baud_tick.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = UART_MAX_DATA_BITS,
  parameter int IDX_W         = UART_IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     baud_tick,
  input  logic                     tx_valid,
  input  logic [MAX_DATA_BITS-1:0] tx_data,
  output logic                     tx_ready,
  input  logic [3:0]               cfg_data_bits,
  input  logic                     cfg_parity_en,
  input  logic                     cfg_parity_odd,
  input  logic                     cfg_two_stop,
  output logic                     tx,
  output logic [IDX_W-1:0]         bit_idx,
  output logic                     busy,
  output logic                     done
);

  uart_state_e              state_r;
  logic [MAX_DATA_BITS-1:0] data_r;
  logic [MAX_DATA_BITS-1:0] shift_r;
  logic [3:0]               len_r;
  logic                     par_en_r;
  logic                     par_odd_r;
  logic                     two_stop_r;
  logic [3:0]               data_cnt_r;
  logic                     stop_cnt_r;
  logic                     tx_r;
  logic [IDX_W-1:0]         bit_idx_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     parity_s;

  // Parity is derived from the latched word, so cfg/data changes mid-frame cannot reach tx.
  uart_parity_gen #(.W(MAX_DATA_BITS)) u_parity (
    .data   (data_r),
    .len    (len_r),
    .odd    (par_odd_r),
    .parity (parity_s)
  );

  assign tx_ready = (state_r == IDLE);
  assign tx       = tx_r;
  assign bit_idx  = bit_idx_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // Frame sequencer: handshake, bit shifting, position counting and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      data_r     <= '0;
      shift_r    <= '0;
      len_r      <= 4'd0;
      par_en_r   <= 1'b0;
      par_odd_r  <= 1'b0;
      two_stop_r <= 1'b0;
      data_cnt_r <= 4'd0;
      stop_cnt_r <= 1'b0;
      tx_r       <= 1'b1;
      bit_idx_r  <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // A baud_tick coincident with accept is deliberately not consumed here.
          if (tx_valid) begin
            data_r     <= tx_data;
            shift_r    <= tx_data;
            len_r      <= clamp_data_bits(cfg_data_bits, MAX_DATA_BITS);
            par_en_r   <= cfg_parity_en;
            par_odd_r  <= cfg_parity_odd;
            two_stop_r <= cfg_two_stop;
            data_cnt_r <= 4'd0;
            stop_cnt_r <= 1'b0;
            state_r    <= START;
            tx_r       <= 1'b0;
            busy_r     <= 1'b1;
            bit_idx_r  <= '0;
          end
        end
        START: begin
          if (baud_tick) begin
            state_r    <= DATA;
            tx_r       <= shift_r[0];
            data_cnt_r <= 4'd0;
            bit_idx_r  <= bit_idx_r + IDX_W'(1);
          end
        end
        DATA: begin
          if (baud_tick) begin
            bit_idx_r <= bit_idx_r + IDX_W'(1);
            if (data_cnt_r == (len_r - 4'd1)) begin
              stop_cnt_r <= 1'b0;
              if (par_en_r) begin
                state_r <= PARITY;
                tx_r    <= parity_s;
              end else begin
                state_r <= STOP;
                tx_r    <= 1'b1;
              end
            end else begin
              data_cnt_r <= data_cnt_r + 4'd1;
              shift_r    <= shift_r >> 1;
              tx_r       <= shift_r[1];
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            state_r    <= STOP;
            tx_r       <= 1'b1;
            stop_cnt_r <= 1'b0;
            bit_idx_r  <= bit_idx_r + IDX_W'(1);
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (two_stop_r && !stop_cnt_r) begin
              stop_cnt_r <= 1'b1;
              bit_idx_r  <= bit_idx_r + IDX_W'(1);
            end else begin
              state_r   <= IDLE;
              busy_r    <= 1'b0;
              bit_idx_r <= '0;
              done_r    <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: frame formats, handshake timing, reset and config latching.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       tx_valid;
  logic [8:0] tx_data;
  logic       tx_ready;
  logic [3:0] cfg_data_bits;
  logic       cfg_parity_en;
  logic       cfg_parity_odd;
  logic       cfg_two_stop;
  logic       tx;
  logic [3:0] bit_idx;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  logic       obs_tx   [0:15];
  logic [3:0] obs_idx  [0:15];
  logic       obs_busy [0:15];
  logic       obs_done [0:15];

  logic       etx, ebusy, edone;
  logic [3:0] eidx;
  logic [15:0] exp_bits;

  uart_tx_framer dut (
    .clk            (clk),
    .rst            (rst),
    .baud_tick      (baud_tick),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_two_stop   (cfg_two_stop),
    .tx             (tx),
    .bit_idx        (bit_idx),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // One clock: drive at negedge, return at the next negedge with outputs settled.
  task automatic cyc(input logic t);
    baud_tick = t;
    @(negedge clk);
    baud_tick = 1'b0;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic snap(input int k);
    obs_tx[k]   = tx;
    obs_idx[k]  = bit_idx;
    obs_busy[k] = busy;
    obs_done[k] = done;
  endtask

  // n baud intervals of 16 clocks, snapshotting the line after each tick.
  task automatic run_ticks(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (15) cyc(1'b0);
      cyc(1'b1);
      snap(first + i + 1);
    end
  endtask

  task automatic offer(input logic [8:0] d, input logic [3:0] nb, input logic pe,
                       input logic po, input logic ts, input logic keep_valid);
    tx_data        = d;
    cfg_data_bits  = nb;
    cfg_parity_en  = pe;
    cfg_parity_odd = po;
    cfg_two_stop   = ts;
    tx_valid       = 1'b1;
    cyc(1'b0);
    if (!keep_valid) tx_valid = 1'b0;
    snap(0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    total++;
    if ({tx, bit_idx, busy, done, tx_ready} !== {1'b1, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset: got tx=%b idx=%0d busy=%b done=%b rdy=%b, want 1 0 0 0 1",
               tx, bit_idx, busy, done, tx_ready);
    end
    rst = 1'b0;
    cyc(1'b0);
  endtask

  task automatic test_8n1();
    int d0;
    d0 = done_cnt;
    exp_bits = 16'h02AA;
    offer(9'h055, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    run_ticks(0, 10);
    cyc(1'b0);
    for (int k = 0; k <= 10; k++) begin
      etx = (k < 10) ? exp_bits[k] : 1'b1;
      eidx = (k < 10) ? 4'(k) : 4'd0;
      ebusy = (k < 10);
      edone = (k == 10);
      total++;
      if ({obs_tx[k], obs_idx[k], obs_busy[k], obs_done[k]} !== {etx, eidx, ebusy, edone}) begin
        bad++;
        $display("FAIL 8n1 pos %0d: got tx=%b idx=%0d busy=%b done=%b, want tx=%b idx=%0d busy=%b done=%b",
                 k, obs_tx[k], obs_idx[k], obs_busy[k], obs_done[k], etx, eidx, ebusy, edone);
      end
    end
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL 8n1 done pulses: got %0d, want 1", done_cnt - d0);
    end
  endtask

  task automatic test_7e1();
    exp_bits = 16'h0346;
    offer(9'h0A3, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(0, 10);
    for (int k = 0; k <= 10; k++) begin
      etx = (k < 10) ? exp_bits[k] : 1'b1;
      eidx = (k < 10) ? 4'(k) : 4'd0;
      ebusy = (k < 10);
      edone = (k == 10);
      total++;
      if ({obs_tx[k], obs_idx[k], obs_busy[k], obs_done[k]} !== {etx, eidx, ebusy, edone}) begin
        bad++;
        $display("FAIL 7e1 pos %0d: got tx=%b idx=%0d busy=%b done=%b, want tx=%b idx=%0d busy=%b done=%b",
                 k, obs_tx[k], obs_idx[k], obs_busy[k], obs_done[k], etx, eidx, ebusy, edone);
      end
    end
  endtask

  task automatic test_8o2();
    exp_bits = 16'h0E1E;
    offer(9'h00F, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    run_ticks(0, 12);
    for (int k = 0; k <= 12; k++) begin
      etx = (k < 12) ? exp_bits[k] : 1'b1;
      eidx = (k < 12) ? 4'(k) : 4'd0;
      ebusy = (k < 12);
      edone = (k == 12);
      total++;
      if ({obs_tx[k], obs_idx[k], obs_busy[k], obs_done[k]} !== {etx, eidx, ebusy, edone}) begin
        bad++;
        $display("FAIL 8o2 pos %0d: got tx=%b idx=%0d busy=%b done=%b, want tx=%b idx=%0d busy=%b done=%b",
                 k, obs_tx[k], obs_idx[k], obs_busy[k], obs_done[k], etx, eidx, ebusy, edone);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_bits = 16'h02AA;
    offer(9'h055, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    tx_data = 9'h00F;
    run_ticks(0, 10);
    for (int k = 0; k <= 10; k++) begin
      etx = (k < 10) ? exp_bits[k] : 1'b1;
      eidx = (k < 10) ? 4'(k) : 4'd0;
      ebusy = (k < 10);
      edone = (k == 10);
      total++;
      if ({obs_tx[k], obs_idx[k], obs_busy[k], obs_done[k]} !== {etx, eidx, ebusy, edone}) begin
        bad++;
        $display("FAIL b2b first pos %0d: got tx=%b idx=%0d busy=%b done=%b, want tx=%b idx=%0d busy=%b done=%b",
                 k, obs_tx[k], obs_idx[k], obs_busy[k], obs_done[k], etx, eidx, ebusy, edone);
      end
    end
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b ready at done: got %b, want 1", tx_ready);
    end
    cyc(1'b0);
    tx_valid = 1'b0;
    snap(0);
    exp_bits = 16'h021E;
    run_ticks(0, 10);
    for (int k = 0; k <= 10; k++) begin
      etx = (k < 10) ? exp_bits[k] : 1'b1;
      eidx = (k < 10) ? 4'(k) : 4'd0;
      ebusy = (k < 10);
      edone = (k == 10);
      total++;
      if ({obs_tx[k], obs_idx[k], obs_busy[k], obs_done[k]} !== {etx, eidx, ebusy, edone}) begin
        bad++;
        $display("FAIL b2b second pos %0d: got tx=%b idx=%0d busy=%b done=%b, want tx=%b idx=%0d busy=%b done=%b",
                 k, obs_tx[k], obs_idx[k], obs_busy[k], obs_done[k], etx, eidx, ebusy, edone);
      end
    end
  endtask

  task automatic test_tick_at_accept();
    tx_data = 9'h055;
    cfg_data_bits = 4'd8;
    cfg_parity_en = 1'b0;
    cfg_parity_odd = 1'b0;
    cfg_two_stop = 1'b0;
    tx_valid = 1'b1;
    cyc(1'b1);
    tx_valid = 1'b0;
    repeat (5) cyc(1'b0);
    total++;
    if ({tx, bit_idx, busy} !== {1'b0, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL tick_at_accept start: got tx=%b idx=%0d busy=%b, want 0 0 1", tx, bit_idx, busy);
    end
    cyc(1'b1);
    total++;
    if ({tx, bit_idx} !== {1'b1, 4'd1}) begin
      bad++;
      $display("FAIL tick_at_accept first data: got tx=%b idx=%0d, want 1 1", tx, bit_idx);
    end
    run_ticks(1, 9);
    total++;
    if ({obs_tx[10], obs_idx[10], obs_busy[10], obs_done[10]} !== {1'b1, 4'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL tick_at_accept end: got tx=%b idx=%0d busy=%b done=%b, want 1 0 0 1",
               obs_tx[10], obs_idx[10], obs_busy[10], obs_done[10]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    offer(9'h055, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    run_ticks(0, 4);
    d0 = done_cnt;
    rst = 1'b1;
    cyc(1'b0);
    rst = 1'b0;
    total++;
    if ({obs_idx[4], tx, bit_idx, busy, done} !== {4'd4, 1'b1, 4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid reset: got idx_before=%0d tx=%b idx=%0d busy=%b done=%b, want 4 1 0 0 0",
               obs_idx[4], tx, bit_idx, busy, done);
    end
    run_ticks(0, 8);
    total++;
    if ({done_cnt - d0, tx} !== {32'd0, 1'b1}) begin
      bad++;
      $display("FAIL mid reset quiet: got done pulses=%0d tx=%b, want 0 1", done_cnt - d0, tx);
    end
    exp_bits = 16'h02AA;
    offer(9'h055, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    run_ticks(0, 10);
    for (int k = 0; k <= 10; k++) begin
      etx = (k < 10) ? exp_bits[k] : 1'b1;
      eidx = (k < 10) ? 4'(k) : 4'd0;
      ebusy = (k < 10);
      edone = (k == 10);
      total++;
      if ({obs_tx[k], obs_idx[k], obs_busy[k], obs_done[k]} !== {etx, eidx, ebusy, edone}) begin
        bad++;
        $display("FAIL post reset pos %0d: got tx=%b idx=%0d busy=%b done=%b, want tx=%b idx=%0d busy=%b done=%b",
                 k, obs_tx[k], obs_idx[k], obs_busy[k], obs_done[k], etx, eidx, ebusy, edone);
      end
    end
  endtask

  // Config/data changed right after accept; then the new (clamped 3->5, odd, 2 stop) format is sent.
  task automatic test_cfg_change();
    exp_bits = 16'h02AA;
    offer(9'h055, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    tx_data = 9'h1E0;
    cfg_data_bits = 4'd3;
    cfg_parity_en = 1'b1;
    cfg_parity_odd = 1'b1;
    cfg_two_stop = 1'b1;
    run_ticks(0, 10);
    for (int k = 0; k <= 10; k++) begin
      etx = (k < 10) ? exp_bits[k] : 1'b1;
      eidx = (k < 10) ? 4'(k) : 4'd0;
      ebusy = (k < 10);
      edone = (k == 10);
      total++;
      if ({obs_tx[k], obs_idx[k], obs_busy[k], obs_done[k]} !== {etx, eidx, ebusy, edone}) begin
        bad++;
        $display("FAIL cfg old pos %0d: got tx=%b idx=%0d busy=%b done=%b, want tx=%b idx=%0d busy=%b done=%b",
                 k, obs_tx[k], obs_idx[k], obs_busy[k], obs_done[k], etx, eidx, ebusy, edone);
      end
    end
    exp_bits = 16'h01C0;
    offer(9'h1E0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    run_ticks(0, 9);
    for (int k = 0; k <= 9; k++) begin
      etx = (k < 9) ? exp_bits[k] : 1'b1;
      eidx = (k < 9) ? 4'(k) : 4'd0;
      ebusy = (k < 9);
      edone = (k == 9);
      total++;
      if ({obs_tx[k], obs_idx[k], obs_busy[k], obs_done[k]} !== {etx, eidx, ebusy, edone}) begin
        bad++;
        $display("FAIL cfg new pos %0d: got tx=%b idx=%0d busy=%b done=%b, want tx=%b idx=%0d busy=%b done=%b",
                 k, obs_tx[k], obs_idx[k], obs_busy[k], obs_done[k], etx, eidx, ebusy, edone);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    baud_tick = 1'b0;
    tx_valid = 1'b0;
    tx_data = 9'h000;
    cfg_data_bits = 4'd8;
    cfg_parity_en = 1'b0;
    cfg_parity_odd = 1'b0;
    cfg_two_stop = 1'b0;
    @(negedge clk);
    test_reset();
    test_8n1();
    test_7e1();
    test_8o2();
    test_back_to_back();
    test_tick_at_accept();
    test_reset_mid_frame();
    test_cfg_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
